// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD sequencer and its one-digit adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Nine's complement of one digit; inputs above 9 simply wrap.
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// One-digit BCD adder: s/cout from a + b + cin with decimal correction.
module bcd_digit_alu
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      // Adding 6 and dropping bit 4 is the same as (t + 6)[3:0].
      s    = t[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Multi-digit BCD add/subtract sequencer: one digit per cycle through a
// single shared bcd_digit_alu, carry/borrow rippled in a register.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                Cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             op_r;
  logic [W-1:0]     a_r, b_r;
  logic [3:0]       dig_a, dig_b, alu_s;
  logic             alu_cout;
  logic             accept, last, in_err;

  // Start is honoured whenever no digits are in flight (IDLE or DONE).
  assign accept = start && (state != RUN);
  assign last   = (idx == LAST);

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) in_err = 1'b1;
    end
  end

  always_comb begin
    dig_a = a_r[4*idx +: 4];
    dig_b = op_r ? nines_comp(b_r[4*idx +: 4]) : b_r[4*idx +: 4];
  end

  bcd_digit_alu u_alu (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (alu_s),
    .cout (alu_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_r  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      Cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        op_r  <= op;
        idx   <= '0;
        carry <= op;  // +1 of the ten's complement on subtract
        err   <= in_err;
        Cout  <= 1'b0;
      end else if (state == RUN) begin
        sum[4*idx +: 4] <= alu_s;
        carry           <= alu_cout;
        idx             <= last ? '0 : idx + IDX_W'(1);
        // Final carry of a subtract means no borrow, so invert it.
        if (last) Cout <= op_r ? ~alu_cout : alu_cout;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl (DIGITS=4) with hand-computed results.
module tb_bcd_seq_ctrl;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a, b;
  logic        busy, done, Cout, err;
  logic [15:0] sum;

  int tests = 0;
  int fails = 0;

  bcd_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start now, then checks busy/done every cycle up to the done pulse.
  // inject_at > 0 raises a second start with different operands mid-run.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vop, input logic [15:0] exp_sum, input logic exp_cout,
                        input logic exp_err, input logic chk_sum, input int inject_at);
    a = va; b = vb; op = vop; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_t0"}, busy, 1);
    check({tag, "_done_t0"}, done, 0);
    for (int i = 1; i <= DIGITS; i++) begin
      if (i == inject_at) begin
        start = 1'b1; a = 16'h9999; b = 16'h9999; op = 1'b1;
      end
      step();
      start = 1'b0;
      if (i < DIGITS) begin
        check($sformatf("%s_busy_c%0d", tag, i), busy, 1);
        check($sformatf("%s_done_c%0d", tag, i), done, 0);
      end else begin
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_cout"}, Cout, exp_cout);
        check({tag, "_err"}, err, exp_err);
        if (chk_sum) check({tag, "_sum"}, sum, exp_sum);
      end
    end
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", Cout, 0);
    check("rst_err", err, 0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();

    run_op("add", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 0);
    step();
    run_op("add_ovf", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    step();
    run_op("sub", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b1, 0);
    step();
    run_op("sub_brw", 16'h0100, 16'h0200, 1'b1, 16'h9900, 1'b1, 1'b0, 1'b1, 0);
    step();
    check("hold_sum", sum, 16'h9900);
    check("hold_cout", Cout, 1);
    run_op("inval", 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    step();
    check("hold_err", err, 1);
    run_op("clr_err", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 0);
    step();

    // Second start two cycles into RUN must be ignored.
    run_op("ignore", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 2);
    step();
    check("ignore_done_after", done, 0);
    check("ignore_busy_after", busy, 0);
    check("ignore_sum_after", sum, 16'h6912);

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op("b2b_a", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b1, 0);
    run_op("b2b_b", 16'h0500, 16'h0499, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 0);
    step();

    // Reset mid-RUN aborts with no done pulse.
    a = 16'h1234; b = 16'h5678; op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_cout", Cout, 0);
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < DIGITS + 3; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
